uart_slave_rx_engine: RTL and testbench

// - Synthesizable UART receiver: the slave end of the uart_if serial link. Recovers frames

---
 rtl/uart_slave_rx_engine.sv | 210 +++++++++++++++++++++
 tb/tb_uart_slave_rx_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_slave_rx_engine.sv
// Purpose: UART receiver. Oversamples rx, recovers start/data/parity/stop frames and queues them with error flags.
// Latency: a frame is pushed at the mid-stop-bit decision; rx_valid rises the following clock.
// Backpressure: frames wait in a FIFO_DEPTH FIFO; on a full FIFO with no pop the frame is dropped and overrun_err pulses.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   baud_div[15:0]          clocks per sample tick minus 1 (latched at start detection)
//   rx                      asynchronous serial input, idle high
//   rx_data/rx_valid/rx_ready  head-of-FIFO frame, valid/ready handshake
//   parity_err, framing_err flags belonging to the head frame
//   overrun_err             1-cycle pulse when a completed frame is dropped
//   busy                    receiver FSM is not idle

// Small FIFO: a push into a full FIFO is still accepted when a pop happens in the same cycle.
module uart_slave_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic         overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && !do_push;
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign head_vld = (count != '0);
endmodule

module uart_slave_rx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           baud_div,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  framing_err,
  output logic                  overrun_err,
  output logic                  busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state, state_nxt;

  logic                  rx_meta, rxs;
  logic [15:0]           baud_lat, tick_cnt;
  logic [SW-1:0]         samp_cnt;
  logic                  s0, s1;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic                  par_flag, frm_flag;
  logic                  active, tick, decide, bit_end, maj, start_det, last_stop, push;
  logic [DATA_WIDTH+1:0] push_dat, head_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign active    = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign tick      = active && (tick_cnt == baud_lat);
  assign decide    = tick && (samp_cnt == SW'(OVERSAMPLE/2 + 1));
  assign bit_end   = tick && (samp_cnt == SW'(OVERSAMPLE - 1));
  // Third sample is the live rxs at the decision tick.
  assign maj       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign start_det = (state == IDLE) && !rxs;
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  assign push_dat  = {frm_flag | ~maj, par_flag, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE:      if (!rxs) state_nxt = START;
      START: begin
        if (decide && maj) state_nxt = IDLE;  // false start
        else if (bit_end)  state_nxt = DATA;
      end
      DATA:      if (bit_end && bit_idx == BW'(DATA_WIDTH - 1))
                   state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (bit_end) state_nxt = STOP;
      STOP: begin
        // Leaving mid stop bit lets the next start edge be caught with no gap.
        if (decide && last_stop) begin
          push      = 1'b1;
          state_nxt = rxs ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_lat <= '0;
      tick_cnt <= '0;
      samp_cnt <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_flag <= 1'b0;
      frm_flag <= 1'b0;
    end else if (start_det) begin
      baud_lat <= baud_div;
      tick_cnt <= '0;
      samp_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_flag <= 1'b0;
      frm_flag <= 1'b0;
    end else begin
      if (tick) begin
        tick_cnt <= '0;
        samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
        if (samp_cnt == SW'(OVERSAMPLE/2 - 1)) s0 <= rxs;
        if (samp_cnt == SW'(OVERSAMPLE/2))     s1 <= rxs;
      end else if (active) begin
        tick_cnt <= tick_cnt + 16'd1;
      end
      if (decide) begin
        case (state)
          DATA:    shreg    <= {maj, shreg[DATA_WIDTH-1:1]};
          PARITY:  par_flag <= ((^shreg) ^ maj) != (PARITY_ODD != 0);
          STOP:    if (!maj) frm_flag <= 1'b1;
          default: ;
        endcase
      end
      if (bit_end) begin
        if (state == DATA) bit_idx  <= bit_idx + 1'b1;
        if (state == STOP) stop_idx <= 1'b1;
      end
    end
  end

  uart_slave_rx_fifo #(.W(DATA_WIDTH + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (rx_valid && rx_ready),
    .head_dat (head_dat),
    .head_vld (rx_valid),
    .overrun  (overrun_err)
  );

  assign rx_data     = head_dat[DATA_WIDTH-1:0];
  assign parity_err  = head_dat[DATA_WIDTH];
  assign framing_err = head_dat[DATA_WIDTH+1];
  assign busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_slave_rx_engine.sv
module tb_uart_slave_rx_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic        rx = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, framing_err, overrun_err, busy;

  uart_slave_rx_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_div    (baud_div),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int exp_ovr = 0;
  int last_pop_cyc = -1;
  int stop_cyc = 0;
  logic [9:0] exp_q[$];  // {framing, parity, data} in arrival order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Consumer side: every accepted frame is compared with the oldest expected frame.
  always @(negedge clk) begin : monitor
    logic [9:0] e;
    cyc++;
    if (rst_n) begin
      if (overrun_err) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        check("pop_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e[7:0]));
          check("parity_err", 32'(parity_err), 32'(e[8]));
          check("framing_err", 32'(framing_err), 32'(e[9]));
        end
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int len);
    rx = b;
    wait_clk(len);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    if (n > 0) wait_clk(n);
  endtask

  // Drives one 8E1-style frame; rx is left at the stop-bit level.
  // The expected entry is recorded up front from the frame contents.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input logic scramble);
    int len;
    logic [15:0] bd_save;
    logic pe;
    len = 16 * (int'(baud_div) + 1);
    bd_save = baud_div;
    pe = (($countones(d) + int'(pbit)) % 2) != 0;
    if (!rx_ready && exp_q.size() >= 4) exp_ovr++;
    else exp_q.push_back({~sbit, pe, d});
    drive_bit(1'b0, len);
    if (scramble) baud_div = baud_div + 16'd3;
    for (int i = 0; i < 8; i++) drive_bit(d[i], len);
    drive_bit(pbit, len);
    stop_cyc = cyc;
    drive_bit(sbit, len);
    baud_div = bd_save;
  endtask

  initial begin
    logic [7:0] d;
    logic pbit, sbit;
    int bd;

    // Reset state
    wait_clk(3);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    check("rst_framing_err", 32'(framing_err), 0);
    check("rst_overrun_err", 32'(overrun_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    rx_ready = 1'b1;
    wait_clk(5);

    // Clean frame and its latency from the stop bit start
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle(32);
    check("a5_latency_ok", 32'(last_pop_cyc > stop_cyc && (last_pop_cyc - stop_cyc) <= 32), 1);
    check("a5_busy_after", 32'(busy), 0);

    // Wrong parity
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    idle(32);
    check("par_drained", exp_q.size(), 0);

    // Short low glitch is a false start
    rx = 1'b0;
    wait_clk(4);
    idle(30);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_valid", 32'(rx_valid), 0);

    // Stop bit low, line held low: one entry, receiver parked until rx goes high
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_clk(40);
    check("break_busy", 32'(busy), 1);
    check("break_one_entry", exp_q.size(), 0);
    idle(48);
    check("break_released", 32'(busy), 0);
    send_frame(8'h66, 1'b0, 1'b1, 1'b0);
    idle(32);
    check("after_break_rx", exp_q.size(), 0);

    // FIFO full and overrun
    rx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = 8'h10 + 8'(k);
      send_frame(d, ^d, 1'b1, 1'b0);
      idle(4);
    end
    idle(32);
    check("ovr_pulses", ovr_cnt, exp_ovr);
    check("ovr_model_once", exp_ovr, 1);
    check("full_valid", 32'(rx_valid), 1);
    check("full_head_stable", 32'(rx_data), 32'h10);
    check("full_held", exp_q.size(), 4);
    rx_ready = 1'b1;
    wait_clk(10);
    check("drain_done", exp_q.size(), 0);
    check("drain_valid", 32'(rx_valid), 0);

    // Reset in the middle of data bit 3
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    rx = 1'b0;
    wait_clk(8);
    rst_n = 1'b0;
    wait_clk(2);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(rx_valid), 0);
    check("midrst_data", 32'(rx_data), 0);
    check("midrst_flags", 32'({parity_err, framing_err, overrun_err}), 0);
    rx = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    idle(32);
    check("midrst_only_5a", exp_q.size(), 0);

    // Random frames: data, parity, stop level, baud rate, mid-frame baud_div changes
    for (int n = 0; n < 12; n++) begin
      bd = $urandom_range(0, 2);
      baud_div = 16'(bd);
      d = 8'($urandom);
      pbit = (^d) ^ ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 4) != 0);
      send_frame(d, pbit, sbit, 1'($urandom_range(0, 1)));
      idle(sbit ? int'($urandom_range(0, 10)) : 8 + int'($urandom_range(0, 10)));
    end
    idle(160);
    check("rand_all_received", exp_q.size(), 0);
    check("rand_no_overrun", ovr_cnt, exp_ovr);
    check("rand_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
